// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 bus sink: FSM state encoding, opcode
// bit positions, DDRAM window and wrap addresses, the blank character, and
// small helpers for address stepping and visible-store indexing.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT8  = 2'd0,  // 8-bit interface: every strobe is a full instruction
    ST_NIB_HI = 2'd1,  // 4-bit interface, waiting for the high nibble
    ST_NIB_LO = 2'd2   // 4-bit interface, waiting for the low nibble
  } lcd_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         LINE_CHARS  = 16;
  localparam int         STORE_CHARS = 2 * LINE_CHARS;

  // The last address of each 40-character DDRAM line, and the first address
  // of the line that follows it.
  localparam logic [6:0] LINE1_FIRST = 7'h00;
  localparam logic [6:0] LINE1_LAST  = 7'h27;
  localparam logic [6:0] LINE2_FIRST = 7'h40;
  localparam logic [6:0] LINE2_LAST  = 7'h67;

  // Instruction class is selected by the highest set bit of the byte.
  localparam int OP_BIT_DDRAM = 7;
  localparam int OP_BIT_CGRAM = 6;
  localparam int OP_BIT_FUNC  = 5;
  localparam int OP_BIT_SHIFT = 4;
  localparam int OP_BIT_DISP  = 3;
  localparam int OP_BIT_ENTRY = 2;
  localparam int OP_BIT_HOME  = 1;
  localparam int OP_BIT_CLEAR = 0;

  localparam int FUNC_BIT_DL  = 4;
  localparam int DISP_BIT_D   = 2;
  localparam int ENTRY_BIT_ID = 1;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // Clear and home are the slow instructions on the real controller.
  function automatic logic lcd_is_long_op(input logic [7:0] b);
    return (b == OP_CLEAR) || (b == OP_HOME);
  endfunction

  // Only 0x00-0x0F and 0x40-0x4F are on the glass of a 2x16 panel.
  function automatic logic lcd_visible(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  // Visible store slot: line 2 occupies slots 16..31.
  function automatic logic [4:0] lcd_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Address counter step with the controller's line wrap. An address parked
  // in the unused gap of either line jumps to the start of the next line on
  // any step, whichever direction is selected.
  function automatic logic [6:0] lcd_next_addr(input logic [6:0] a, input logic inc);
    if (a > LINE1_LAST && a < LINE2_FIRST) return LINE2_FIRST;
    if (a > LINE2_LAST) return LINE1_FIRST;
    if (inc) begin
      if (a == LINE1_LAST) return LINE2_FIRST;
      if (a == LINE2_LAST) return LINE1_FIRST;
      return a + 7'd1;
    end
    if (a == LINE2_FIRST) return LINE1_LAST;
    if (a == LINE1_FIRST) return LINE2_LAST;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync
// Brings the asynchronous LCD pins into the clk domain, measures how long the
// synchronized E stayed high, and reports each falling edge of E as either a
// valid strobe or a short-E event, together with the RS/RW/data captured on
// the last cycle E was still high.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   lcd_rs/rw/e  raw bus control pins
//   lcd_data     raw data nibble {lcd7,lcd6,lcd5,lcd4}
//   strobe       1-cycle pulse: E fell after at least E_MIN_CYC high cycles
//   short_e      1-cycle pulse: E fell after fewer than E_MIN_CYC high cycles
//   rs, rw       bus control captured with the strobe
//   nibble       data nibble captured with the strobe
module lcd_bus_sync #(
  parameter int E_MIN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [3:0] lcd_data,
  output logic       strobe,
  output logic       short_e,
  output logic       rs,
  output logic       rw,
  output logic [3:0] nibble
);

  localparam int CNT_W = $clog2(E_MIN_CYC + 2);
  localparam logic [CNT_W-1:0] E_MIN = CNT_W'(E_MIN_CYC);

  // Bus word layout: {e, rw, rs, data[3:0]}
  logic [6:0] bus_meta;
  logic [6:0] bus_sync;
  logic [6:0] bus_dly;
  logic [CNT_W-1:0] e_cnt;
  logic e_fall;

  // One extra delay stage keeps the sampled data aligned with the last
  // high cycle of E, so fast data hold after the falling edge is harmless.
  assign e_fall = bus_dly[6] & ~bus_sync[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_meta <= '0;
      bus_sync <= '0;
      bus_dly  <= '0;
      e_cnt    <= '0;
      strobe   <= 1'b0;
      short_e  <= 1'b0;
      rs       <= 1'b0;
      rw       <= 1'b0;
      nibble   <= '0;
    end else begin
      bus_meta <= {lcd_e, lcd_rw, lcd_rs, lcd_data};
      bus_sync <= bus_meta;
      bus_dly  <= bus_sync;
      // Saturating high-time counter; only needs to reach E_MIN.
      if (bus_sync[6]) begin
        if (e_cnt < E_MIN) e_cnt <= e_cnt + 1'b1;
      end else begin
        e_cnt <= '0;
      end
      strobe  <= e_fall && (e_cnt >= E_MIN);
      short_e <= e_fall && (e_cnt < E_MIN);
      rw      <= bus_dly[5];
      rs      <= bus_dly[4];
      nibble  <= bus_dly[3:0];
    end
  end

endmodule

// File: rtl/lcd_hd44780_sink.sv
// lcd_hd44780_sink
// Receive-side model of a 4-bit HD44780 write bus. Rebuilds the visible 2x16
// DDRAM window, tracks the address counter and display-on bit, and flags
// protocol violations. Optional busy-time checking is enabled by defining
// LCD_SINK_BUSY_EN; without it timing_err is constant low.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   lcd_rs/rw/e        bus control pins (asynchronous)
//   lcd4..lcd7         bus data nibble bits 0..3 (asynchronous)
//   line1, line2       DDRAM 0x00-0x0F / 0x40-0x4F, column 0 in [127:120]
//   disp_on            display-control D bit
//   addr               DDRAM address counter
//   upd                1-cycle pulse on a visible write or a clear
//   proto_err          sticky protocol error
//   timing_err         sticky strobe-while-busy error
module lcd_hd44780_sink
  import lcd_pkg::*;
#(
  parameter int E_MIN_CYC   = 2,
  parameter int NIB_TIMEOUT = 50000,
  parameter int CMD_CYC     = 2000,
  parameter int CLEAR_CYC   = 82000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic         lcd4,
  input  logic         lcd5,
  input  logic         lcd6,
  input  logic         lcd7,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         disp_on,
  output logic [6:0]   addr,
  output logic         upd,
  output logic         proto_err,
  output logic         timing_err
);

  localparam int TO_W = $clog2(NIB_TIMEOUT + 1);
  localparam logic [TO_W-1:0] NIB_LAST = TO_W'(NIB_TIMEOUT - 1);

  logic       strobe;
  logic       short_e;
  logic       s_rs;
  logic       s_rw;
  logic [3:0] s_nib;

  lcd_state_t      state;
  logic [3:0]      hi_nib;
  logic            hi_rs;
  logic [TO_W-1:0] nib_cnt;
  logic            id;
  logic            cgram_sel;
  logic [7:0]      ddram [STORE_CHARS];

  logic       accept;
  logic       exec;
  logic [7:0] cur_byte;

  lcd_bus_sync #(.E_MIN_CYC(E_MIN_CYC)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data ({lcd7, lcd6, lcd5, lcd4}),
    .strobe   (strobe),
    .short_e  (short_e),
    .rs       (s_rs),
    .rw       (s_rw),
    .nibble   (s_nib)
  );

  for (genvar i = 0; i < LINE_CHARS; i++) begin : g_cols
    assign line1[8*(LINE_CHARS-1-i) +: 8] = ddram[i];
    assign line2[8*(LINE_CHARS-1-i) +: 8] = ddram[LINE_CHARS+i];
  end

  // A byte executes on an accepted instruction strobe in 8-bit mode, or on
  // an accepted low nibble whose RS agrees with the high nibble.
  always_comb begin
    accept   = strobe && !s_rw;
    cur_byte = (state == ST_INIT8) ? {s_nib, 4'h0} : {hi_nib, s_nib};
    exec     = 1'b0;
    case (state)
      ST_INIT8:  exec = accept && !s_rs;
      ST_NIB_LO: exec = accept && (s_rs == hi_rs);
      default:   exec = 1'b0;
    endcase
  end

  // Main FSM, instruction decoder and visible store. State changes from the
  // nibble protocol come first; a function-set instruction executed in the
  // same cycle overrides them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT8;
      hi_nib    <= '0;
      hi_rs     <= 1'b0;
      nib_cnt   <= '0;
      addr      <= '0;
      id        <= 1'b1;
      cgram_sel <= 1'b0;
      disp_on   <= 1'b0;
      upd       <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < STORE_CHARS; i++) ddram[i] <= ASCII_SPACE;
    end else begin
      upd <= 1'b0;
      if (short_e || (strobe && s_rw)) proto_err <= 1'b1;

      case (state)
        ST_INIT8: begin
        end
        ST_NIB_HI: begin
          if (accept) begin
            hi_nib  <= s_nib;
            hi_rs   <= s_rs;
            nib_cnt <= '0;
            state   <= ST_NIB_LO;
          end
        end
        ST_NIB_LO: begin
          if (accept) begin
            if (s_rs != hi_rs) proto_err <= 1'b1;
            state <= ST_NIB_HI;
          end else if (nib_cnt == NIB_LAST) begin
            proto_err <= 1'b1;
            state     <= ST_NIB_HI;
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
        default: state <= ST_INIT8;
      endcase

      if (exec) begin
        if (s_rs) begin
          // CGRAM writes are not modelled; the address counter stays put.
          if (!cgram_sel) begin
            if (lcd_visible(addr)) begin
              ddram[lcd_index(addr)] <= cur_byte;
              upd <= 1'b1;
            end
            addr <= lcd_next_addr(addr, id);
          end
        end else if (cur_byte[OP_BIT_DDRAM]) begin
          addr      <= cur_byte[6:0];
          cgram_sel <= 1'b0;
        end else if (cur_byte[OP_BIT_CGRAM]) begin
          cgram_sel <= 1'b1;
        end else if (cur_byte[OP_BIT_FUNC]) begin
          state <= cur_byte[FUNC_BIT_DL] ? ST_INIT8 : ST_NIB_HI;
        end else if (cur_byte[OP_BIT_SHIFT]) begin
          // Cursor/display shift does not change stored characters.
        end else if (cur_byte[OP_BIT_DISP]) begin
          disp_on <= cur_byte[DISP_BIT_D];
        end else if (cur_byte[OP_BIT_ENTRY]) begin
          id <= cur_byte[ENTRY_BIT_ID];
        end else if (cur_byte[OP_BIT_HOME]) begin
          addr      <= '0;
          cgram_sel <= 1'b0;
        end else if (cur_byte[OP_BIT_CLEAR]) begin
          for (int i = 0; i < STORE_CHARS; i++) ddram[i] <= ASCII_SPACE;
          addr      <= '0;
          id        <= 1'b1;
          cgram_sel <= 1'b0;
          upd       <= 1'b1;
        end
      end
    end
  end

`ifdef LCD_SINK_BUSY_EN
  localparam int BUSY_MAX = (CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC;
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

  logic [BUSY_W-1:0] busy_cnt;
  logic              long_op;

  // Everything in 8-bit mode is treated as a slow init instruction.
  assign long_op = (state == ST_INIT8) || lcd_is_long_op(cur_byte);

  // Busy window after each executed byte; a strobe inside it is flagged but
  // the byte is still processed normally by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt   <= '0;
      timing_err <= 1'b0;
    end else begin
      if (strobe && (busy_cnt != '0)) timing_err <= 1'b1;
      if (exec) begin
        busy_cnt <= long_op ? BUSY_W'(CLEAR_CYC) : BUSY_W'(CMD_CYC);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
      end
    end
  end
`else
  // No busy model in this build; both busy lengths are non-negative, so this
  // is constant low while keeping the parameter set identical across builds.
  assign timing_err = (CMD_CYC < 0) || (CLEAR_CYC < 0);
`endif

endmodule
